// File: rtl/br_resolve_unit_if.sv
// Retirement-side bus of the branch resolve unit: two retire slots in,
// BTB correction, flush/redirect control and statistics out.
interface br_resolve_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 retire_valid0;
    logic                 retire_is_br0;
    logic [63:0]          retire_pc0;
    logic [63:0]          retire_pred_npc0;
    logic [63:0]          retire_actual_npc0;
    logic                 retire_valid1;
    logic                 retire_is_br1;
    logic [63:0]          retire_pc1;
    logic [63:0]          retire_pred_npc1;
    logic [63:0]          retire_actual_npc1;

    logic                 rob_mis_pred;
    logic [63:0]          rob_mis_pred_pc;
    logic [63:0]          rob_correct_npc;
    logic                 flush;
    logic                 if_redirect_valid;
    logic [63:0]          if_redirect_pc;
    logic                 retire_stall;
    logic [CNT_WIDTH-1:0] br_count;
    logic [CNT_WIDTH-1:0] mis_count;

    // ROB / retirement side
    modport master (
        output retire_valid0, retire_is_br0, retire_pc0, retire_pred_npc0, retire_actual_npc0,
        output retire_valid1, retire_is_br1, retire_pc1, retire_pred_npc1, retire_actual_npc1,
        input  rob_mis_pred, rob_mis_pred_pc, rob_correct_npc, flush,
        input  if_redirect_valid, if_redirect_pc, retire_stall, br_count, mis_count
    );

    // resolve unit side
    modport slave (
        input  retire_valid0, retire_is_br0, retire_pc0, retire_pred_npc0, retire_actual_npc0,
        input  retire_valid1, retire_is_br1, retire_pc1, retire_pred_npc1, retire_actual_npc1,
        output rob_mis_pred, rob_mis_pred_pc, rob_correct_npc, flush,
        output if_redirect_valid, if_redirect_pc, retire_stall, br_count, mis_count
    );
endinterface

// File: rtl/br_resolve_unit.sv
// Branch resolve unit: detects retire-time mispredicts on two slots, drives the
// BTB correction and a fixed-length flush/redirect, and keeps saturating stats.
module br_resolve_unit #(
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_WIDTH    = 32
) (
    input logic              clock,
    input logic              reset,
    br_resolve_unit_if.slave br
);
    localparam int FC = (FLUSH_CYCLES < 1) ? 1 : FLUSH_CYCLES;
    localparam int FW = (FC > 1) ? $clog2(FC) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FC - 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t               state_q, state_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;

    logic                 br0, br1, mp0, mp1, hit;
    logic [63:0]          sel_pc, sel_npc;
    logic [1:0]           br_inc;

    logic                 mis_pred_q, mis_pred_d;
    logic                 flush_q, flush_d;
    logic [63:0]          pc_q, pc_d;
    logic [63:0]          npc_q, npc_d;
    logic [CNT_WIDTH-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                    input logic [1:0] inc);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, a} + (CNT_WIDTH + 1)'(inc);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // Slot 0 is older: its mispredict squashes slot 1 entirely.
    always_comb begin
        br0     = br.retire_valid0 & br.retire_is_br0;
        br1     = br.retire_valid1 & br.retire_is_br1;
        mp0     = br0 & (br.retire_pred_npc0 != br.retire_actual_npc0);
        mp1     = br1 & (br.retire_pred_npc1 != br.retire_actual_npc1);
        hit     = mp0 | mp1;
        sel_pc  = mp0 ? br.retire_pc0 : br.retire_pc1;
        sel_npc = mp0 ? br.retire_actual_npc0 : br.retire_actual_npc1;
        br_inc  = mp0 ? {1'b0, br0} : ({1'b0, br0} + {1'b0, br1});
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    fcnt_d = fcnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                fcnt_d  = '0;
            end
        endcase
    end

    // Next values of the registered outputs; retirement is ignored outside IDLE.
    always_comb begin
        mis_pred_d = 1'b0;
        pc_d       = pc_q;
        npc_d      = npc_q;
        br_cnt_d   = br_cnt_q;
        mis_cnt_d  = mis_cnt_q;
        flush_d    = (state_d == FLUSH);
        if (state_q == IDLE) begin
            br_cnt_d  = sat_add(br_cnt_q, br_inc);
            mis_cnt_d = sat_add(mis_cnt_q, {1'b0, hit});
            if (hit) begin
                mis_pred_d = 1'b1;
                pc_d       = sel_pc;
                npc_d      = sel_npc;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mis_pred_q <= 1'b0;
            flush_q    <= 1'b0;
            pc_q       <= '0;
            npc_q      <= '0;
            br_cnt_q   <= '0;
            mis_cnt_q  <= '0;
        end else begin
            mis_pred_q <= mis_pred_d;
            flush_q    <= flush_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            br_cnt_q   <= br_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
        end
    end

    assign br.rob_mis_pred      = mis_pred_q;
    assign br.rob_mis_pred_pc   = pc_q;
    assign br.rob_correct_npc   = npc_q;
    assign br.if_redirect_valid = mis_pred_q;
    assign br.if_redirect_pc    = npc_q;
    assign br.flush             = flush_q;
    assign br.retire_stall      = flush_q;
    assign br.br_count          = br_cnt_q;
    assign br.mis_count         = mis_cnt_q;
endmodule

// File: tb/tb_br_resolve_unit.sv
// Scoreboard bench for br_resolve_unit: a 32-bit-counter instance for function
// and flush sequencing, and a 4-bit-counter instance for saturation.
module tb_br_resolve_unit;
    logic clock;
    logic reset;

    br_resolve_unit_if #(.CNT_WIDTH(32)) ifa ();
    br_resolve_unit_if #(.CNT_WIDTH(4))  ifb ();

    br_resolve_unit #(.FLUSH_CYCLES(3), .CNT_WIDTH(32)) u_dut (
        .clock(clock),
        .reset(reset),
        .br   (ifa.slave)
    );

    br_resolve_unit #(.FLUSH_CYCLES(3), .CNT_WIDTH(4)) u_sat (
        .clock(clock),
        .reset(reset),
        .br   (ifb.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] npc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          pushed = 0;
    int          strobes = 0;
    int          run_f = 0;
    int          run_s = 0;
    int          ign = 0;
    int unsigned m_br = 0;
    int unsigned m_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One retire cycle on the main instance plus the reference model update.
    task automatic cyc(input logic v0, input logic b0, input logic [63:0] pc0,
                       input logic [63:0] p0, input logic [63:0] a0,
                       input logic v1, input logic b1, input logic [63:0] pc1,
                       input logic [63:0] p1, input logic [63:0] a1);
        bit c0, c1;
        @(posedge clock);
        #1;
        ifa.retire_valid0 = v0; ifa.retire_is_br0 = b0; ifa.retire_pc0 = pc0;
        ifa.retire_pred_npc0 = p0; ifa.retire_actual_npc0 = a0;
        ifa.retire_valid1 = v1; ifa.retire_is_br1 = b1; ifa.retire_pc1 = pc1;
        ifa.retire_pred_npc1 = p1; ifa.retire_actual_npc1 = a1;
        c0 = v0 && b0;
        c1 = v1 && b1;
        if (ign > 0) begin
            ign--;
        end else if (c0 && (p0 != a0)) begin
            m_br++; m_mis++; ign = 3; pushed++;
            sb.push_back('{pc: pc0, npc: a0});
        end else begin
            m_br += int'(c0) + int'(c1);
            if (c1 && (p1 != a1)) begin
                m_mis++; ign = 3; pushed++;
                sb.push_back('{pc: pc1, npc: a1});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_br"}, ifa.br_count, 64'(m_br));
        check({tag, "_mis"}, ifa.mis_count, 64'(m_mis));
    endtask

    // Strobe scoreboard and flush/stall run-length checks.
    always @(negedge clock) begin
        if (reset) begin
            run_f = 0;
            run_s = 0;
        end else begin
            if (ifa.rob_mis_pred) begin
                if (sb.size() == 0) begin
                    check("spurious_strobe", 1, 0);
                end else begin
                    e = sb.pop_front();
                    strobes++;
                    check("mis_pred_pc", ifa.rob_mis_pred_pc, e.pc);
                    check("correct_npc", ifa.rob_correct_npc, e.npc);
                    check("redirect_pc", ifa.if_redirect_pc, e.npc);
                    check("redirect_valid", ifa.if_redirect_valid, 1);
                    check("flush_at_strobe", ifa.flush, 1);
                end
            end
            if (ifa.flush) run_f++;
            else if (run_f != 0) begin
                check("flush_len", run_f, 3);
                run_f = 0;
            end
            if (ifa.retire_stall) run_s++;
            else if (run_s != 0) begin
                check("stall_len", run_s, 3);
                run_s = 0;
            end
        end
    end

    initial begin
        reset = 1'b1;
        ifa.retire_valid0 = 0; ifa.retire_is_br0 = 0; ifa.retire_pc0 = 0;
        ifa.retire_pred_npc0 = 0; ifa.retire_actual_npc0 = 0;
        ifa.retire_valid1 = 0; ifa.retire_is_br1 = 0; ifa.retire_pc1 = 0;
        ifa.retire_pred_npc1 = 0; ifa.retire_actual_npc1 = 0;
        ifb.retire_valid0 = 0; ifb.retire_is_br0 = 0; ifb.retire_pc0 = 0;
        ifb.retire_pred_npc0 = 0; ifb.retire_actual_npc0 = 0;
        ifb.retire_valid1 = 0; ifb.retire_is_br1 = 0; ifb.retire_pc1 = 0;
        ifb.retire_pred_npc1 = 0; ifb.retire_actual_npc1 = 0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mis_pred", ifa.rob_mis_pred, 0);
        check("rst_flush", ifa.flush, 0);
        check("rst_stall", ifa.retire_stall, 0);
        check("rst_pc", ifa.rob_mis_pred_pc, 0);
        check("rst_npc", ifa.rob_correct_npc, 0);
        check_counts("rst");
        reset = 1'b0;

        // slot 0 mispredict
        cyc(1, 1, 64'h1000, 64'h1004, 64'h2000, 0, 0, 0, 0, 0);
        idle(1);
        check("t1_br_const", ifa.br_count, 1);
        check("t1_mis_const", ifa.mis_count, 1);
        idle(4);
        check("t1_pc_hold", ifa.rob_mis_pred_pc, 64'h1000);
        check("t1_strobe_gone", ifa.rob_mis_pred, 0);

        // both slots mispredict: slot 1 squashed
        cyc(1, 1, 64'h40, 64'h44, 64'h80, 1, 1, 64'h44, 64'h48, 64'h90);
        idle(5);
        check_counts("both_mp");

        // slot 0 correct, slot 1 mispredict
        cyc(1, 1, 64'h100, 64'h104, 64'h104, 1, 1, 64'h104, 64'h108, 64'h800);
        idle(5);
        check_counts("slot1_mp");

        // correct pair, non-branch with differing NPC, slot 1 alone, bit-63 only
        cyc(1, 1, 64'h200, 64'h204, 64'h204, 1, 1, 64'h204, 64'h300, 64'h300);
        cyc(1, 0, 64'h300, 64'h304, 64'h999, 1, 0, 64'h304, 64'h0, 64'h1);
        idle(1);
        check("no_flush", ifa.flush, 0);
        check_counts("no_mp");
        cyc(0, 1, 64'h400, 64'h404, 64'h500, 1, 1, 64'h600, 64'h604, 64'h700);
        idle(5);
        cyc(1, 1, 64'h800, 64'h8000_0000_0000_0804, 64'h804, 0, 0, 0, 0, 0);
        idle(5);
        check_counts("v1_only_bit63");

        // mispredicts during FLUSH ignored; first IDLE cycle restarts
        cyc(1, 1, 64'hA00, 64'hA04, 64'hB00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(1, 1, 64'hC00 + 64'(i), 64'h1, 64'h2, 1, 1, 64'hD00, 64'h3, 64'h4);
        cyc(1, 1, 64'hE00, 64'hE04, 64'hF00, 0, 0, 0, 0, 0);
        idle(5);
        check_counts("b2b");

        // reset in the second FLUSH cycle
        cyc(1, 1, 64'h1234, 64'h1238, 64'h5678, 0, 0, 0, 0, 0);
        idle(2);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_flush", ifa.flush, 0);
        check("mid_rst_stall", ifa.retire_stall, 0);
        check("mid_rst_mis_pred", ifa.rob_mis_pred, 0);
        check("mid_rst_pc", ifa.rob_mis_pred_pc, 0);
        check("mid_rst_br", ifa.br_count, 0);
        check("mid_rst_mis", ifa.mis_count, 0);
        ign = 0; m_br = 0; m_mis = 0;
        #4;
        reset = 1'b0;
        idle(2);
        check("post_rst_flush", ifa.flush, 0);
        check("post_rst_pc", ifa.rob_mis_pred_pc, 0);
        cyc(1, 1, 64'h2000, 64'h2004, 64'h3000, 0, 0, 0, 0, 0);
        idle(5);
        check_counts("post_rst");

        // saturation on the 4-bit instance
        for (int i = 0; i < 7; i++) begin
            @(posedge clock);
            #1;
            ifb.retire_valid0 = 1; ifb.retire_is_br0 = 1;
            ifb.retire_pc0 = 64'h10 * 64'(i); ifb.retire_pred_npc0 = 64'h4; ifb.retire_actual_npc0 = 64'h4;
            ifb.retire_valid1 = 1; ifb.retire_is_br1 = 1;
            ifb.retire_pc1 = 64'h4; ifb.retire_pred_npc1 = 64'h8; ifb.retire_actual_npc1 = 64'h8;
        end
        @(posedge clock);
        #1;
        check("sat_pre", ifb.br_count, 14);
        @(posedge clock);
        #1;
        check("sat_plus2", ifb.br_count, 15);
        @(posedge clock);
        #1;
        check("sat_hold", ifb.br_count, 15);
        ifb.retire_valid0 = 0; ifb.retire_valid1 = 0;
        @(posedge clock);
        #1;
        check("sat_mis", ifb.mis_count, 0);
        check("sat_flush", ifb.flush, 0);

        idle(2);
        check("sb_empty", 64'(sb.size()), 0);
        check("strobe_count", 64'(strobes), 64'(pushed));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/br_resolve_unit.md
Name: br_resolve_unit

Overview:
- Writer side of the branch target buffer's update interface.
- Sits at ROB retirement for both retire slots. It compares each retiring branch's predicted next-PC against its resolved next-PC.
- On a mismatch it drives the BTB correction triple (rob_mis_pred, rob_mis_pred_pc, rob_correct_npc) and sequences a pipeline flush/redirect.
- It also keeps saturating branch/mispredict statistics counters.

Parameters:
- FLUSH_CYCLES, 3, cycles the flush state is held (minimum 1).
- CNT_WIDTH, 32, width of each statistics counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- retire_valid0  in  1  slot 0 (oldest) retiring this cycle.
- retire_is_br0  in  1  slot 0 is a control-flow instruction.
- retire_pc0  in  64  slot 0 PC.
- retire_pred_npc0  in  64  slot 0 NPC predicted at fetch.
- retire_actual_npc0  in  64  slot 0 resolved NPC.
- retire_valid1, retire_is_br1, retire_pc1, retire_pred_npc1, retire_actual_npc1  in  1/1/64/64/64  same fields for slot 1 (younger).
- rob_mis_pred  out  1  one-cycle BTB correction strobe.
- rob_mis_pred_pc  out  64  PC of the mispredicted branch.
- rob_correct_npc  out  64  correct target to write into the BTB.
- flush  out  1  squash the whole pipeline.
- if_redirect_valid  out  1  one-cycle fetch redirect strobe.
- if_redirect_pc  out  64  fetch restart PC (equals rob_correct_npc).
- retire_stall  out  1  ROB must not retire while high.
- br_count  out  CNT_WIDTH  retired branches.
- mis_count  out  CNT_WIDTH  mispredicted branches.

Behaviour:
- Reset (async, active-high): FSM to IDLE. All outputs 0, including PC/NPC registers and counters.
- Mispredict per slot: mpN = retire_validN & retire_is_brN & (retire_pred_npcN != retire_actual_npcN). The compare is a full 64-bit compare; no alignment masking is applied.
- Slot priority: slot 0 is older.
  - If mp0, slot 1 is squashed: not counted, not checked.
  - Otherwise, if mp1, slot 1 is the mispredict.
  - Non-branch valid slots never mispredict and are not counted.
- FSM states: IDLE, FLUSH.
- IDLE with a mispredict in cycle T (all outputs registered, latency 1):
  - At T+1: rob_mis_pred=1 and if_redirect_valid=1 for exactly one cycle.
  - At T+1: rob_mis_pred_pc = the offending PC; rob_correct_npc = if_redirect_pc = its actual NPC.
  - At T+1: flush=1 and retire_stall=1; FSM enters FLUSH with the down-counter loaded with FLUSH_CYCLES-1.
- FLUSH:
  - flush=1 and retire_stall=1 every cycle.
  - Counter decrements each cycle; when it reaches 0, next state is IDLE.
  - Total flush/stall high time = FLUSH_CYCLES cycles.
  - retire_* inputs are ignored entirely: no counting, no detection.
- rob_mis_pred_pc and rob_correct_npc hold their last values until the next mispredict. if_redirect_pc tracks rob_correct_npc.
- Counters, updated in IDLE only, registered:
  - br_count += number of counted branches (0, 1 or 2; only 1 when slot 1 is squashed).
  - mis_count += 1 per mispredict.
  - Both saturate at all-ones, never wrap. A +2 from all-ones-minus-1 also saturates.
- Both slots correct: no strobe, no state change.
- retire_valid0=0 with retire_valid1=1 is legal; slot 1 is evaluated normally.
- Reset asserted mid-FLUSH: immediate return to IDLE, all outputs 0. No residual strobe after release.
- First cycle after FLUSH (IDLE): retirement accepted normally. A mispredict there restarts the sequence (back-to-back).

Test Plan:
- Reset released, slot 0 branch pc=0x1000, pred=0x1004, actual=0x2000 -> next cycle rob_mis_pred=1, rob_mis_pred_pc=0x1000, rob_correct_npc=0x2000, if_redirect_pc=0x2000; flush/retire_stall high exactly 3 cycles; mis_count=1, br_count=1.
- Both slots branches: slot 0 mispredicted (pc=0x40), slot 1 mispredicted (pc=0x44) -> only pc 0x40 reported; br_count=1, mis_count=1.
- Slot 0 correct branch (pc=0x100, pred=actual=0x104), slot 1 mispredicted (pc=0x104, actual=0x800) -> rob_mis_pred_pc=0x104, rob_correct_npc=0x800; br_count=2.
- Mispredict inputs driven during the 3 FLUSH cycles -> no second strobe, counters unchanged. A mispredict on the first IDLE cycle -> a new strobe one cycle later.
- CNT_WIDTH=4, br_count preset to 14 via a run of correct branches, then two correct branches in one cycle -> br_count=15 and stays 15.
- Reset asserted during the second FLUSH cycle -> flush, retire_stall, rob_mis_pred, rob_mis_pred_pc and counters go to 0 asynchronously; IDLE after release.
